// File: rtl/hazard_ctl.sv
// Hazard control unit for the 5-stage MIPS pipeline: load-use stalls, jump/branch flushes, memory-busy freeze.
// Optional macro HCU_PERF_CNT_EN adds saturating stall/flush performance counters.
module hazard_ctl #(
   parameter int LDSTALL_CYC = 1,
   parameter int CNT_W       = 16
) (
   input  logic       clk_HCU,
   input  logic       rst_HCU,
   input  logic [4:0] ifid_rs_HCU,
   input  logic [4:0] ifid_rt_HCU,
   input  logic       ifid_usesRt_HCU,
   input  logic       ifid_jump_HCU,
   input  logic       idex_memRead_HCU,
   input  logic [4:0] idex_rt_HCU,
   input  logic       exmem_brTaken_HCU,
   input  logic       mem_busy_HCU,
   output logic       pcWrite_HCU,
   output logic       ifidWrite_HCU,
   output logic       ifidFlush_HCU,
   output logic       idexBubble_HCU,
   output logic       exmemFlush_HCU,
   output logic [1:0] state_HCU
`ifdef HCU_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] stallCnt_HCU,
   output logic [CNT_W-1:0] flushCnt_HCU
`endif
);

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_LDSTALL = 2'd1,
      ST_MWAIT   = 2'd2
   } state_t;

   localparam int STALL_W = 2;

   if (LDSTALL_CYC < 1 || LDSTALL_CYC > 3 || CNT_W < 1) begin : g_bad_param
      $error("hazard_ctl: LDSTALL_CYC must be 1..3 and CNT_W >= 1");
   end

   state_t             r_state, w_state_nxt;
   state_t             r_ret, w_ret_nxt;
   logic [STALL_W-1:0] r_cnt, w_cnt_nxt;
   state_t             w_eff;
   logic               w_ldhaz;
   logic               w_stall_evt;
   logic               w_flush_evt;

   assign w_ldhaz = idex_memRead_HCU && (idex_rt_HCU != 5'd0) &&
                    ((idex_rt_HCU == ifid_rs_HCU) ||
                     (ifid_usesRt_HCU && (idex_rt_HCU == ifid_rt_HCU)));

   // Leaving MWAIT, the cycle is judged by the rules of the state we froze in.
   assign w_eff = (r_state == ST_MWAIT) ? r_ret : r_state;

   always_ff @(posedge clk_HCU or posedge rst_HCU) begin
      if (rst_HCU) begin
         r_state <= ST_RUN;
         r_ret   <= ST_RUN;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ret   <= w_ret_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      pcWrite_HCU    = 1'b1;
      ifidWrite_HCU  = 1'b1;
      ifidFlush_HCU  = 1'b0;
      idexBubble_HCU = 1'b0;
      exmemFlush_HCU = 1'b0;
      w_state_nxt    = w_eff;
      w_ret_nxt      = r_ret;
      w_cnt_nxt      = r_cnt;
      w_stall_evt    = 1'b0;
      w_flush_evt    = 1'b0;

      if (mem_busy_HCU) begin
         pcWrite_HCU   = 1'b0;
         ifidWrite_HCU = 1'b0;
         w_state_nxt   = ST_MWAIT;
         w_ret_nxt     = w_eff;
         w_stall_evt   = 1'b1;
      end else if (exmem_brTaken_HCU) begin
         ifidFlush_HCU  = 1'b1;
         idexBubble_HCU = 1'b1;
         exmemFlush_HCU = 1'b1;
         w_cnt_nxt      = '0;
         w_state_nxt    = ST_RUN;
         w_flush_evt    = 1'b1;
      end else if (w_eff == ST_LDSTALL) begin
         pcWrite_HCU    = 1'b0;
         ifidWrite_HCU  = 1'b0;
         idexBubble_HCU = 1'b1;
         w_stall_evt    = 1'b1;
         if (r_cnt != '0) w_cnt_nxt = r_cnt - 1'b1;
         if (r_cnt <= STALL_W'(1)) w_state_nxt = ST_RUN;
      end else if (w_ldhaz) begin
         pcWrite_HCU    = 1'b0;
         ifidWrite_HCU  = 1'b0;
         idexBubble_HCU = 1'b1;
         w_stall_evt    = 1'b1;
         if (LDSTALL_CYC > 1) begin
            w_cnt_nxt   = STALL_W'(LDSTALL_CYC - 1);
            w_state_nxt = ST_LDSTALL;
         end
      end else if (ifid_jump_HCU) begin
         ifidFlush_HCU = 1'b1;
         w_flush_evt   = 1'b1;
      end

      if (rst_HCU) begin
         pcWrite_HCU    = 1'b0;
         ifidWrite_HCU  = 1'b0;
         ifidFlush_HCU  = 1'b1;
         idexBubble_HCU = 1'b1;
         exmemFlush_HCU = 1'b1;
      end
   end

   assign state_HCU = r_state;

`ifdef HCU_PERF_CNT_EN
   always_ff @(posedge clk_HCU or posedge rst_HCU) begin
      if (rst_HCU) begin
         stallCnt_HCU <= '0;
         flushCnt_HCU <= '0;
      end else begin
         if (w_stall_evt && (stallCnt_HCU != '1)) stallCnt_HCU <= stallCnt_HCU + 1'b1;
         if (w_flush_evt && (flushCnt_HCU != '1)) flushCnt_HCU <= flushCnt_HCU + 1'b1;
      end
   end
`else
   logic w_perf_unused;
   assign w_perf_unused = w_stall_evt ^ w_flush_evt;
`endif

endmodule

// File: tb/tb_hazard_ctl.sv
// Scoreboard bench for hazard_ctl: two instances (LDSTALL_CYC 2 and 3) share stimulus and are
// checked against a cycle-level behavioural model; perf counters checked when HCU_PERF_CNT_EN is set.
module tb_hazard_ctl;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [4:0] ifid_rs = '0, ifid_rt = '0, idex_rt = '0;
   logic       uses_rt = 1'b0, jump = 1'b0, mem_rd = 1'b0, br = 1'b0, busy = 1'b0;

   logic [6:0] act [2];
   logic [1:0] st2, st3;
   logic       pw2, iw2, ifl2, bub2, exf2, pw3, iw3, ifl3, bub3, exf3;
`ifdef HCU_PERF_CNT_EN
   logic [3:0] sc2, fc2, sc3, fc3;
`endif

   always #5 clk = ~clk;

   hazard_ctl #(.LDSTALL_CYC(2), .CNT_W(4)) dut2 (
      .clk_HCU(clk), .rst_HCU(rst), .ifid_rs_HCU(ifid_rs), .ifid_rt_HCU(ifid_rt),
      .ifid_usesRt_HCU(uses_rt), .ifid_jump_HCU(jump), .idex_memRead_HCU(mem_rd),
      .idex_rt_HCU(idex_rt), .exmem_brTaken_HCU(br), .mem_busy_HCU(busy),
      .pcWrite_HCU(pw2), .ifidWrite_HCU(iw2), .ifidFlush_HCU(ifl2),
      .idexBubble_HCU(bub2), .exmemFlush_HCU(exf2), .state_HCU(st2)
`ifdef HCU_PERF_CNT_EN
      , .stallCnt_HCU(sc2), .flushCnt_HCU(fc2)
`endif
   );

   hazard_ctl #(.LDSTALL_CYC(3), .CNT_W(4)) dut3 (
      .clk_HCU(clk), .rst_HCU(rst), .ifid_rs_HCU(ifid_rs), .ifid_rt_HCU(ifid_rt),
      .ifid_usesRt_HCU(uses_rt), .ifid_jump_HCU(jump), .idex_memRead_HCU(mem_rd),
      .idex_rt_HCU(idex_rt), .exmem_brTaken_HCU(br), .mem_busy_HCU(busy),
      .pcWrite_HCU(pw3), .ifidWrite_HCU(iw3), .ifidFlush_HCU(ifl3),
      .idexBubble_HCU(bub3), .exmemFlush_HCU(exf3), .state_HCU(st3)
`ifdef HCU_PERF_CNT_EN
      , .stallCnt_HCU(sc3), .flushCnt_HCU(fc3)
`endif
   );

   assign act[0] = {pw2, iw2, ifl2, bub2, exf2, st2};
   assign act[1] = {pw3, iw3, ifl3, bub3, exf3, st3};

   typedef struct {
      logic [6:0] outs [2];
      int         sc [2];
      int         fc [2];
      int         cyc;
   } exp_t;

   exp_t q[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;

   // Model: remaining stall cycles, whether last cycle was frozen, perf counts.
   int   stall_left [2] = '{0, 0};
   bit   was_busy [2]   = '{0, 0};
   int   m_sc [2]       = '{0, 0};
   int   m_fc [2]       = '{0, 0};
   int   ld_len [2]     = '{2, 3};

   task automatic chk(input string name, input int k, input int c, input int a, input int e);
      n_chk++;
      if (a != e) begin
         n_fail++;
         $display("FAIL %s dut%0d cycle %0d: got %0h, expected %0h", name, ld_len[k], c, a, e);
      end
   endtask

   always @(negedge clk) begin
      while (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         for (int k = 0; k < 2; k++) begin
            chk("outputs{pc,ifw,ifl,bub,exf,st}", k, e.cyc, int'(act[k]), int'(e.outs[k]));
`ifdef HCU_PERF_CNT_EN
            chk("stallCnt", k, e.cyc, int'(k == 0 ? sc2 : sc3), e.sc[k]);
            chk("flushCnt", k, e.cyc, int'(k == 0 ? fc2 : fc3), e.fc[k]);
`endif
         end
      end
   end

   task automatic step(input bit r, input bit bsy, input bit b, input bit j, input bit mr,
                       input logic [4:0] irt, input logic [4:0] rs, input logic [4:0] rt,
                       input bit ur);
      exp_t e;
      @(posedge clk);
      #1;
      rst = r; busy = bsy; br = b; jump = j; mem_rd = mr;
      idex_rt = irt; ifid_rs = rs; ifid_rt = rt; uses_rt = ur;
      cyc++;
      e.cyc = cyc;
      for (int k = 0; k < 2; k++) begin
         bit pc, ifw, ifl, bub, exf, stall_ev, flush_ev, haz;
         int st;
         if (r) begin
            stall_left[k] = 0; was_busy[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
            e.outs[k] = 7'b0011100;
            e.sc[k] = 0; e.fc[k] = 0;
            continue;
         end
         st = was_busy[k] ? 2 : (stall_left[k] > 0 ? 1 : 0);
         e.sc[k] = m_sc[k]; e.fc[k] = m_fc[k];
         pc = 1; ifw = 1; ifl = 0; bub = 0; exf = 0; stall_ev = 0; flush_ev = 0;
         haz = mr && (irt != 0) && (irt == rs || (ur && irt == rt));
         if (bsy) begin
            pc = 0; ifw = 0; stall_ev = 1;
         end else if (b) begin
            ifl = 1; bub = 1; exf = 1; flush_ev = 1; stall_left[k] = 0;
         end else if (stall_left[k] > 0) begin
            pc = 0; ifw = 0; bub = 1; stall_ev = 1; stall_left[k]--;
         end else if (haz) begin
            pc = 0; ifw = 0; bub = 1; stall_ev = 1; stall_left[k] = ld_len[k] - 1;
         end else if (j) begin
            ifl = 1; flush_ev = 1;
         end
         was_busy[k] = bsy;
         if (stall_ev && m_sc[k] < 15) m_sc[k]++;
         if (flush_ev && m_fc[k] < 15) m_fc[k]++;
         e.outs[k] = {pc, ifw, ifl, bub, exf, 2'(st)};
      end
      q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
   endtask

   task automatic load_use();
      step(0, 0, 0, 0, 1, 5'd8, 5'd8, 5'd3, 0);
   endtask

   initial begin
      step(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
      step(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
      idle(2);
      // load-use, then same with rt = 0 (never stalls), then rt-match path
      load_use(); idle(4);
      step(0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1); idle(2);
      step(0, 0, 0, 0, 1, 5'd9, 5'd1, 5'd9, 1); idle(4);
      step(0, 0, 0, 0, 1, 5'd9, 5'd1, 5'd9, 0); idle(1);
      // single taken branch, then branch cancelling a stall
      step(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0); idle(2);
      load_use(); step(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0); idle(3);
      // freeze during a stall
      load_use();
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
      idle(4);
      // reset mid-stall
      load_use(); step(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0); idle(2);
      // long freeze saturates the stall counter, then one jump
      for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
      step(0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0); idle(2);
      // jump with load-use: stall wins, jump re-seen afterwards
      step(0, 0, 0, 1, 1, 5'd8, 5'd8, 5'd0, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
      idle(2);
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(99) < 2, $urandom_range(99) < 12, $urandom_range(99) < 10,
              $urandom_range(99) < 25, $urandom_range(99) < 50,
              5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3)),
              1'($urandom_range(1)));
      end
      idle(2);
      @(posedge clk);
      @(posedge clk);
      if (q.size() != 0) begin
         n_chk++; n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/hazard_ctl.md
Name: hazard_ctl

Overview:
- Pipeline hazard controller for the 5-stage MIPS datapath.
- Generates write-enable, flush and bubble controls for PC, IF/ID, ID/EX (BF1) and EX/MEM (BF2).
- Handles three cases:
  - load-use stalls (multi-cycle, parameterised);
  - control-hazard flushes for jumps resolved in ID and branches resolved in MEM;
  - whole-pipeline freeze while data memory is busy.
- Small registered FSM with a stall counter; all outputs are Mealy (state + current inputs).

Parameters:
- LDSTALL_CYC, 1, load-use stall length in cycles (1 with forwarding, 2 without); legal range 1..3.
- CNT_W, 16, width of the performance counters (used only with the optional feature).

Ports:
- clk_HCU  in  1  pipeline clock, rising edge.
- rst_HCU  in  1  asynchronous, active-high reset.
- ifid_rs_HCU  in  5  rs field of the instruction in IF/ID.
- ifid_rt_HCU  in  5  rt field of the instruction in IF/ID.
- ifid_usesRt_HCU  in  1  1 = the IF/ID instruction reads rt as a source.
- ifid_jump_HCU  in  1  the IF/ID instruction is j/jal (jump decided in ID).
- idex_memRead_HCU  in  1  ID/EX holds a load (M bit from BF1).
- idex_rt_HCU  in  5  destination rt of the instruction in ID/EX.
- exmem_brTaken_HCU  in  1  branch in EX/MEM is resolved taken.
- mem_busy_HCU  in  1  data memory is not ready; freeze the pipeline.
- pcWrite_HCU  out  1  PC register write enable.
- ifidWrite_HCU  out  1  IF/ID write enable.
- ifidFlush_HCU  out  1  load NOP into IF/ID.
- idexBubble_HCU  out  1  force M/EX/WB into BF1 to zero.
- exmemFlush_HCU  out  1  force M/WB into BF2 to zero.
- state_HCU  out  2  current FSM state: 0 RUN, 1 LDSTALL, 2 MWAIT.

Behaviour:
- Reset:
  - state = RUN, stall counter = 0.
  - While rst_HCU is high: pcWrite = ifidWrite = 0; ifidFlush = idexBubble = exmemFlush = 1.
- Defaults (no hazard, RUN): pcWrite = ifidWrite = 1; all flush/bubble outputs = 0.
- Load-use hazard detection:
  - ldHaz = idex_memRead & (idex_rt != 0) & ((idex_rt == ifid_rs) | (ifid_usesRt & idex_rt == ifid_rt)).
  - Evaluated only in RUN.
- Priority, highest first: reset > mem_busy > exmem_brTaken > ldHaz > ifid_jump.
- mem_busy = 1 (any state):
  - All enables 0, all flush/bubble outputs 0 (pure freeze).
  - Next state = MWAIT; the return state and stall counter are held.
  - When busy drops, return to the saved state (RUN or LDSTALL) with the counter unchanged.
  - MWAIT is exited the first cycle mem_busy = 0; that cycle is evaluated with the saved state's rules.
- exmem_brTaken = 1, not busy:
  - pcWrite = 1 (target selected externally); ifidWrite = 1.
  - ifidFlush = idexBubble = exmemFlush = 1.
  - Any pending load stall is cancelled: counter = 0, next state = RUN.
  - Penalty is exactly 3 bubbles.
- ldHaz in RUN, no busy or branch:
  - pcWrite = ifidWrite = 0, idexBubble = 1.
  - If LDSTALL_CYC > 1: counter loads LDSTALL_CYC - 1, next state = LDSTALL.
- LDSTALL, no busy or branch:
  - Same stall outputs; counter decrements each cycle.
  - Next state = RUN when counter == 1.
  - Total stall = LDSTALL_CYC cycles.
- ifid_jump in RUN, none of the above: pcWrite = 1, ifidFlush = 1 for one cycle (1-cycle penalty).
- Jump coinciding with ldHaz: the stall wins; the jump is re-seen once IF/ID resumes.
- ldHaz with idex_rt == 0 never stalls.
- Counter never wraps below 0.

Optional Feature:
- Macro HCU_PERF_CNT_EN.
- When defined, adds two outputs:
  - stallCnt_HCU out CNT_W: increments each cycle pcWrite = 0 due to a load stall or mem_busy (reset excluded).
  - flushCnt_HCU out CNT_W: increments each cycle exmem_brTaken or a jump flush is applied.
- Both counters clear on reset and saturate at all-ones (no wrap).
- When undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset pulse mid-stall (LDSTALL, counter = 1): outputs go to reset values immediately; after release state = RUN, pcWrite = 1.
- LDSTALL_CYC = 2; idex_memRead = 1, idex_rt = 8, ifid_rs = 8: pcWrite = 0 and idexBubble = 1 for exactly 2 cycles, state 0→1→0. Same inputs with idex_rt = 0: no stall.
- exmem_brTaken = 1 for 1 cycle in RUN: ifidFlush = idexBubble = exmemFlush = 1 that cycle only, pcWrite = 1.
- Branch taken in cycle 1 of a 2-cycle load stall: flush outputs asserted, stall cancelled, state = RUN next cycle.
- mem_busy high for 3 cycles during LDSTALL (LDSTALL_CYC = 3, counter = 2): all outputs 0, state = 2; after busy drops, 2 more stall cycles, then RUN.
- HCU_PERF_CNT_EN, CNT_W = 4: 20 consecutive mem_busy cycles → stallCnt_HCU saturates at 15; one jump flush → flushCnt_HCU = 1.
